// File: rtl/riscv_trap_ctrl.sv
// Retire-stage trap controller: prioritises exceptions, interrupts and MRET,
// issues a redirect with req/ack, then strobes the mcause/mepc/mtval update.
module riscv_trap_ctrl #(
    parameter int XLEN         = 32,
    parameter bit HAS_VECTORED = 1'b1
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            ex_valid_i,
    input  logic [15:0]     ex_exc_i,
    input  logic [XLEN-1:0] ex_pc_i,
    input  logic [XLEN-1:0] ex_tval_i,
    input  logic            mret_i,
    input  logic [11:0]     mip_i,
    input  logic [11:0]     mie_i,
    input  logic            mstatus_mie_i,
    input  logic [1:0]      prv_i,
    input  logic [XLEN-1:0] mtvec_i,
    input  logic [XLEN-1:0] mepc_i,
    input  logic            trap_ack_i,
    output logic            trap_req_o,
    output logic [XLEN-1:0] trap_pc_o,
    output logic            is_mret_o,
    output logic            stall_o,
    output logic            csr_we_o,
    output logic [XLEN-1:0] mcause_o,
    output logic [XLEN-1:0] mepc_o,
    output logic [XLEN-1:0] mtval_o
);

    localparam logic [1:0]  PRV_M    = 2'b11;
    localparam logic [11:0] IRQ_MASK = 12'hBBB;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        REQ    = 2'd1,
        COMMIT = 2'd2
    } state_t;

    state_t          r_state;
    logic            r_trapReq;
    logic [XLEN-1:0] r_trapPc;
    logic            r_isMret;
    logic            r_stall;
    logic            r_csrWe;
    logic [XLEN-1:0] r_mcause;
    logic [XLEN-1:0] r_mepc;
    logic [XLEN-1:0] r_mtval;

    logic            w_excValid;
    logic [3:0]      w_excCause;
    logic [11:0]     w_irqPend;
    logic            w_irqEn;
    logic [3:0]      w_irqCause;
    logic            w_takeExc;
    logic            w_takeIrq;
    logic            w_takeMret;
    logic [XLEN-1:0] w_trapBase;
    logic            w_vectored;
    logic [XLEN-1:0] w_excTval;
    logic            w_unused;

    // Fixed exception priority; reserved causes 10 and 14 never trap.
    always_comb begin
        w_excValid = 1'b1;
        w_excCause = 4'd0;
        if      (ex_exc_i[3])  w_excCause = 4'd3;
        else if (ex_exc_i[12]) w_excCause = 4'd12;
        else if (ex_exc_i[1])  w_excCause = 4'd1;
        else if (ex_exc_i[2])  w_excCause = 4'd2;
        else if (ex_exc_i[0])  w_excCause = 4'd0;
        else if (ex_exc_i[8])  w_excCause = 4'd8;
        else if (ex_exc_i[9])  w_excCause = 4'd9;
        else if (ex_exc_i[11]) w_excCause = 4'd11;
        else if (ex_exc_i[6])  w_excCause = 4'd6;
        else if (ex_exc_i[4])  w_excCause = 4'd4;
        else if (ex_exc_i[15]) w_excCause = 4'd15;
        else if (ex_exc_i[13]) w_excCause = 4'd13;
        else if (ex_exc_i[7])  w_excCause = 4'd7;
        else if (ex_exc_i[5])  w_excCause = 4'd5;
        else                   w_excValid = 1'b0;
    end

    assign w_irqPend = mip_i & mie_i & IRQ_MASK;
    assign w_irqEn   = (|w_irqPend) && ((prv_i != PRV_M) || mstatus_mie_i);

    always_comb begin
        w_irqCause = 4'd0;
        if      (w_irqPend[11]) w_irqCause = 4'd11;
        else if (w_irqPend[3])  w_irqCause = 4'd3;
        else if (w_irqPend[7])  w_irqCause = 4'd7;
        else if (w_irqPend[9])  w_irqCause = 4'd9;
        else if (w_irqPend[1])  w_irqCause = 4'd1;
        else if (w_irqPend[5])  w_irqCause = 4'd5;
        else if (w_irqPend[8])  w_irqCause = 4'd8;
        else if (w_irqPend[0])  w_irqCause = 4'd0;
        else if (w_irqPend[4])  w_irqCause = 4'd4;
        else                    w_irqCause = 4'd0;
    end

    always_comb begin
        w_excTval = ex_tval_i;
        case (w_excCause)
            4'd3:                w_excTval = ex_pc_i;
            4'd8, 4'd9, 4'd11:   w_excTval = '0;
            default:             w_excTval = ex_tval_i;
        endcase
    end

    assign w_takeExc  = ex_valid_i && w_excValid;
    assign w_takeIrq  = ex_valid_i && !w_excValid && w_irqEn;
    assign w_takeMret = ex_valid_i && !w_excValid && !w_irqEn && mret_i;

    assign w_trapBase = {mtvec_i[XLEN-1:2], 2'b00};
    assign w_vectored = HAS_VECTORED && (mtvec_i[1:0] == 2'b01);

    assign w_unused = ^{ex_exc_i[14], ex_exc_i[10], mip_i[10], mip_i[6], mip_i[2],
                        mie_i[10], mie_i[6], mie_i[2]};

    // Everything the core and CSR file see is registered here so it stays
    // stable for the whole handshake regardless of retire-stage inputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= IDLE;
            r_trapReq <= 1'b0;
            r_trapPc  <= '0;
            r_isMret  <= 1'b0;
            r_stall   <= 1'b0;
            r_csrWe   <= 1'b0;
            r_mcause  <= '0;
            r_mepc    <= '0;
            r_mtval   <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    r_csrWe <= 1'b0;
                    if (w_takeExc || w_takeIrq) begin
                        r_state   <= REQ;
                        r_trapReq <= 1'b1;
                        r_stall   <= 1'b1;
                        r_isMret  <= 1'b0;
                        r_mepc    <= {ex_pc_i[XLEN-1:2], 2'b00};
                        if (w_takeExc) begin
                            r_trapPc <= w_trapBase;
                            r_mcause <= {1'b0, {(XLEN-5){1'b0}}, w_excCause};
                            r_mtval  <= w_excTval;
                        end else begin
                            r_trapPc <= w_vectored ? (w_trapBase + XLEN'({w_irqCause, 2'b00}))
                                                   : w_trapBase;
                            r_mcause <= {1'b1, {(XLEN-5){1'b0}}, w_irqCause};
                            r_mtval  <= '0;
                        end
                    end else if (w_takeMret) begin
                        r_state   <= REQ;
                        r_trapReq <= 1'b1;
                        r_stall   <= 1'b1;
                        r_isMret  <= 1'b1;
                        r_trapPc  <= mepc_i;
                    end
                end
                REQ: begin
                    if (trap_ack_i) begin
                        r_trapReq <= 1'b0;
                        if (r_isMret) begin
                            r_state <= IDLE;
                            r_stall <= 1'b0;
                        end else begin
                            r_state <= COMMIT;
                            r_csrWe <= 1'b1;
                        end
                    end
                end
                COMMIT: begin
                    r_state <= IDLE;
                    r_csrWe <= 1'b0;
                    r_stall <= 1'b0;
                end
                default: begin
                    r_state   <= IDLE;
                    r_trapReq <= 1'b0;
                    r_csrWe   <= 1'b0;
                    r_stall   <= 1'b0;
                end
            endcase
        end
    end

    assign trap_req_o = r_trapReq;
    assign trap_pc_o  = r_trapPc;
    assign is_mret_o  = r_isMret;
    assign stall_o    = r_stall;
    assign csr_we_o   = r_csrWe;
    assign mcause_o   = r_mcause;
    assign mepc_o     = r_mepc;
    assign mtval_o    = r_mtval;

endmodule

// File: tb/tb_riscv_trap_ctrl.sv
// Directed bench for riscv_trap_ctrl: a scoreboard queue holds the expected
// redirect for each issued vector; a monitor checks it when trap_req_o rises.
module tb_riscv_trap_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        ex_valid_i;
    logic [15:0] ex_exc_i;
    logic [31:0] ex_pc_i;
    logic [31:0] ex_tval_i;
    logic        mret_i;
    logic [11:0] mip_i;
    logic [11:0] mie_i;
    logic        mstatus_mie_i;
    logic [1:0]  prv_i;
    logic [31:0] mtvec_i;
    logic [31:0] mepc_i;
    logic        trap_ack_i;
    logic        trap_req_o;
    logic [31:0] trap_pc_o;
    logic        is_mret_o;
    logic        stall_o;
    logic        csr_we_o;
    logic [31:0] mcause_o;
    logic [31:0] mepc_o;
    logic [31:0] mtval_o;

    always #5 clk = ~clk;

    riscv_trap_ctrl #(.XLEN(32), .HAS_VECTORED(1'b1)) dut (
        .clk(clk), .rst(rst),
        .ex_valid_i(ex_valid_i), .ex_exc_i(ex_exc_i), .ex_pc_i(ex_pc_i),
        .ex_tval_i(ex_tval_i), .mret_i(mret_i), .mip_i(mip_i), .mie_i(mie_i),
        .mstatus_mie_i(mstatus_mie_i), .prv_i(prv_i), .mtvec_i(mtvec_i),
        .mepc_i(mepc_i), .trap_ack_i(trap_ack_i),
        .trap_req_o(trap_req_o), .trap_pc_o(trap_pc_o), .is_mret_o(is_mret_o),
        .stall_o(stall_o), .csr_we_o(csr_we_o), .mcause_o(mcause_o),
        .mepc_o(mepc_o), .mtval_o(mtval_o)
    );

    typedef struct {
        logic [31:0] trapPc;
        logic        isMret;
        logic [31:0] mcause;
        logic [31:0] mepc;
        logic [31:0] mtval;
    } expReq_t;

    expReq_t sbQ[$];
    expReq_t monExp;
    int numChecks   = 0;
    int numErrors   = 0;
    int expCsrWe    = 0;
    int csrWePulses = 0;
    int csrWeCycles = 0;
    logic prevReq = 1'b0;
    logic prevWe  = 1'b0;

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        numChecks++;
        if (actual !== expected) begin
            numErrors++;
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, actual, expected);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic expectReq(input logic [31:0] trapPc, input logic isMret,
                             input logic [31:0] mcause, input logic [31:0] mepc,
                             input logic [31:0] mtval);
        expReq_t e;
        e.trapPc = trapPc;
        e.isMret = isMret;
        e.mcause = mcause;
        e.mepc   = mepc;
        e.mtval  = mtval;
        sbQ.push_back(e);
    endtask

    task automatic applyStimulus(input logic [15:0] exc, input logic [31:0] pc,
                                 input logic [31:0] tval, input logic mret);
        ex_valid_i = 1'b1;
        ex_exc_i   = exc;
        ex_pc_i    = pc;
        ex_tval_i  = tval;
        mret_i     = mret;
        tick();
        ex_valid_i = 1'b0;
        ex_exc_i   = '0;
        mret_i     = 1'b0;
    endtask

    task automatic doAck(input logic isMret);
        trap_ack_i = 1'b1;
        tick();
        trap_ack_i = 1'b0;
        checkOutput("req_drop_after_ack", trap_req_o, 32'd0);
        if (!isMret) begin
            checkOutput("csr_we_pulse", csr_we_o, 32'd1);
            checkOutput("stall_in_commit", stall_o, 32'd1);
            tick();
        end
        checkOutput("csr_we_back_low", csr_we_o, 32'd0);
        checkOutput("stall_back_low", stall_o, 32'd0);
    endtask

    task automatic checkAllZero(input string tag);
        checkOutput({tag, "_req"},    trap_req_o, 32'd0);
        checkOutput({tag, "_pc"},     trap_pc_o,  32'd0);
        checkOutput({tag, "_mret"},   is_mret_o,  32'd0);
        checkOutput({tag, "_stall"},  stall_o,    32'd0);
        checkOutput({tag, "_csr_we"}, csr_we_o,   32'd0);
        checkOutput({tag, "_mcause"}, mcause_o,   32'd0);
        checkOutput({tag, "_mepc"},   mepc_o,     32'd0);
        checkOutput({tag, "_mtval"},  mtval_o,    32'd0);
    endtask

    // Monitor: compare each new redirect against the scoreboard head and
    // count csr_we_o pulses and high cycles.
    initial begin
        forever begin
            @(negedge clk);
            if (trap_req_o && !prevReq) begin
                if (sbQ.size() == 0) begin
                    numChecks++;
                    numErrors++;
                    $display("[TB] FAIL unexpected_req: got trap_pc 0x%08h, expected no request", trap_pc_o);
                end else begin
                    monExp = sbQ.pop_front();
                    checkOutput("sb_trap_pc", trap_pc_o, monExp.trapPc);
                    checkOutput("sb_is_mret", is_mret_o, monExp.isMret);
                    checkOutput("sb_mcause",  mcause_o,  monExp.mcause);
                    checkOutput("sb_mepc",    mepc_o,    monExp.mepc);
                    checkOutput("sb_mtval",   mtval_o,   monExp.mtval);
                end
            end
            if (csr_we_o) csrWeCycles++;
            if (csr_we_o && !prevWe) csrWePulses++;
            prevReq = trap_req_o;
            prevWe  = csr_we_o;
        end
    end

    initial begin
        rst = 1'b1;
        ex_valid_i = 1'b0; ex_exc_i = '0; ex_pc_i = '0; ex_tval_i = '0; mret_i = 1'b0;
        mip_i = '0; mie_i = '0; mstatus_mie_i = 1'b0; prv_i = 2'b11;
        mtvec_i = 32'h100; mepc_i = '0; trap_ack_i = 1'b0;
        repeat (3) tick();
        checkAllZero("reset");
        rst = 1'b0;
        tick();

        // Illegal instruction, ack in the first request cycle
        expectReq(32'h100, 1'b0, 32'd2, 32'h200, 32'hDEAD);
        expCsrWe++;
        applyStimulus(16'h0004, 32'h200, 32'hDEAD, 1'b0);
        checkOutput("t1_req_latency", trap_req_o, 32'd1);
        checkOutput("t1_stall", stall_o, 32'd1);
        doAck(1'b0);

        // Breakpoint beats illegal instruction; mtval is the PC
        expectReq(32'h100, 1'b0, 32'd3, 32'h40, 32'h40);
        expCsrWe++;
        applyStimulus(16'h000C, 32'h40, 32'h1234, 1'b0);
        checkOutput("t2_req", trap_req_o, 32'd1);
        doAck(1'b0);

        // MEI beats MTI, vectored: 0x100 + 4*11
        mip_i = 12'h880; mie_i = 12'h880; mstatus_mie_i = 1'b1; prv_i = 2'b11; mtvec_i = 32'h101;
        expectReq(32'h12C, 1'b0, 32'h8000000B, 32'h500, 32'h0);
        expCsrWe++;
        applyStimulus(16'h0000, 32'h500, 32'h99, 1'b0);
        checkOutput("t3_req", trap_req_o, 32'd1);
        doAck(1'b0);

        // Machine mode with MIE clear masks the interrupt
        mstatus_mie_i = 1'b0;
        applyStimulus(16'h0000, 32'h504, 32'h0, 1'b0);
        checkOutput("t4_no_req", trap_req_o, 32'd0);
        checkOutput("t4_no_stall", stall_o, 32'd0);
        tick();
        checkOutput("t4_no_req_later", trap_req_o, 32'd0);

        // User mode takes SSI even with MIE clear; mepc low bits cleared
        prv_i = 2'b00; mip_i = 12'h002; mie_i = 12'h002;
        expectReq(32'h104, 1'b0, 32'h80000001, 32'h508, 32'h0);
        expCsrWe++;
        applyStimulus(16'h0000, 32'h50A, 32'h5, 1'b0);
        doAck(1'b0);

        // MRET: redirect to mepc, CSR outputs untouched, no write strobe
        mip_i = '0; mie_i = '0; prv_i = 2'b11; mepc_i = 32'h3000;
        expectReq(32'h3000, 1'b1, 32'h80000001, 32'h508, 32'h0);
        applyStimulus(16'h0000, 32'h600, 32'h0, 1'b1);
        checkOutput("t6_is_mret", is_mret_o, 32'd1);
        doAck(1'b1);

        // MRET together with ecall from M: the ecall traps
        mtvec_i = 32'h100;
        expectReq(32'h100, 1'b0, 32'd11, 32'h600, 32'h0);
        expCsrWe++;
        applyStimulus(16'h0800, 32'h600, 32'h77, 1'b1);
        checkOutput("t7_not_mret", is_mret_o, 32'd0);
        doAck(1'b0);

        // Exception beats pending interrupt; exceptions ignore vectored mode
        mtvec_i = 32'h101; mip_i = 12'h880; mie_i = 12'h880; mstatus_mie_i = 1'b1;
        expectReq(32'h100, 1'b0, 32'd12, 32'h200, 32'hBEEF);
        expCsrWe++;
        applyStimulus(16'h1003, 32'h203, 32'hBEEF, 1'b0);
        doAck(1'b0);

        // Reserved cause bits alone do nothing
        mip_i = '0; mie_i = '0; mtvec_i = 32'h100;
        applyStimulus(16'h4400, 32'h700, 32'h0, 1'b0);
        checkOutput("t9_reserved_no_req", trap_req_o, 32'd0);

        // Ack held off: outputs stable, new retirements ignored
        expectReq(32'h100, 1'b0, 32'd7, 32'h700, 32'hABC);
        expCsrWe++;
        applyStimulus(16'h0080, 32'h700, 32'hABC, 1'b0);
        for (int i = 0; i < 10; i++) begin
            ex_valid_i = 1'b1; ex_exc_i = 16'h0008; ex_pc_i = 32'h800 + i; ex_tval_i = 32'h55;
            tick();
            checkOutput("hold_req",    trap_req_o, 32'd1);
            checkOutput("hold_stall",  stall_o,    32'd1);
            checkOutput("hold_pc",     trap_pc_o,  32'h100);
            checkOutput("hold_mcause", mcause_o,   32'd7);
            checkOutput("hold_mepc",   mepc_o,     32'h700);
            checkOutput("hold_mtval",  mtval_o,    32'hABC);
        end
        ex_valid_i = 1'b0; ex_exc_i = '0;
        doAck(1'b0);

        // Reset while requesting abandons the request
        expectReq(32'h100, 1'b0, 32'd6, 32'h900, 32'h1);
        applyStimulus(16'h0040, 32'h900, 32'h1, 1'b0);
        checkOutput("t11_req", trap_req_o, 32'd1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        checkAllZero("rst_in_req");
        tick();
        checkOutput("t11_no_csr_we", csr_we_o, 32'd0);
        repeat (2) tick();

        checkOutput("csr_we_pulse_count", csrWePulses, expCsrWe);
        checkOutput("csr_we_cycle_count", csrWeCycles, expCsrWe);
        checkOutput("scoreboard_drained", sbQ.size(), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", numChecks, numErrors);
        $finish;
    end

endmodule
